pwm_duty_meter: RTL and testbench

- Measures a PWM waveform produced by the on-chip PWM generator, or arriving on a pad: per-period high time and period in clock cycles.
- Sits directly downstream of the PWM generator and feeds loopback self-check logic and status readout.
- Also flags a waveform stuck at 0% or 100%, i.e. no edges within a timeout.

---
 rtl/pwm_duty_meter.sv | 151 +++++++++++++++
 tb/tb_pwm_duty_meter.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_duty_meter.sv
// PWM duty meter: measures per-period high time and period (in clk cycles) of
// a PWM waveform and flags a waveform stuck high or low for TIMEOUT cycles.
module pwm_duty_meter #(
  parameter int unsigned CNT_W   = 10,
  parameter int unsigned TIMEOUT = 1000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             pwm_in,
  output logic [CNT_W-1:0] high_cycles,
  output logic [CNT_W-1:0] period_cycles,
  output logic             meas_valid,
  output logic             stuck_high,
  output logic             stuck_low
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StHigh = 2'd1;
  localparam logic [1:0] StLow  = 2'd2;

  localparam logic [CNT_W-1:0] TimeoutVal = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] CntOne     = CNT_W'(1);

  // Input synchronizer and edge-detect delay stage
  logic sync1_q, sync1_d;
  logic s_q, s_d;
  logic p_q, p_d;

  // Measurement state
  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] hi_lat_q, hi_lat_d;
  logic [CNT_W-1:0] high_q, high_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic             valid_q, valid_d;
  logic             stuck_high_q, stuck_high_d;
  logic             stuck_low_q, stuck_low_d;

  logic rise;
  logic fall;
  logic timeout;

  assign rise    = s_q & ~p_q;
  assign fall    = ~s_q & p_q;
  // An edge in the same cycle as saturation takes priority over the timeout.
  assign timeout = (cnt_q == TimeoutVal) & ~rise & ~fall;

  // Synchronizer runs regardless of en so edges are clean when en returns.
  always_comb begin
    sync1_d = pwm_in;
    s_d     = sync1_q;
    p_d     = s_q;
  end

  // Next-state: counter, FSM, latched results and stuck flags
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    hi_lat_d     = hi_lat_q;
    high_d       = high_q;
    period_d     = period_q;
    valid_d      = 1'b0;
    stuck_high_d = stuck_high_q;
    stuck_low_d  = stuck_low_q;

    if (!en) begin
      // Results and flags hold; the partial period is discarded.
      state_d = StIdle;
      cnt_d   = '0;
    end else begin
      if (rise) begin
        cnt_d = CntOne;
      end else if (cnt_q < TimeoutVal) begin
        cnt_d = cnt_q + CntOne;
      end

      if (rise || fall) begin
        stuck_high_d = 1'b0;
        stuck_low_d  = 1'b0;
      end

      case (state_q)
        StIdle: begin
          if (rise) begin
            state_d = StHigh;
          end
        end
        StHigh: begin
          if (fall) begin
            hi_lat_d = cnt_q;
            state_d  = StLow;
          end
        end
        StLow: begin
          if (rise) begin
            high_d   = hi_lat_q;
            period_d = cnt_q;
            valid_d  = 1'b1;
            state_d  = StHigh;
          end
        end
        default: begin
          state_d = StIdle;
        end
      endcase

      if (timeout) begin
        stuck_high_d = s_q;
        stuck_low_d  = ~s_q;
        state_d      = StIdle;
      end
    end
  end

  // State registers with synchronous active-high reset
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q      <= 1'b0;
      s_q          <= 1'b0;
      p_q          <= 1'b0;
      state_q      <= StIdle;
      cnt_q        <= '0;
      hi_lat_q     <= '0;
      high_q       <= '0;
      period_q     <= '0;
      valid_q      <= 1'b0;
      stuck_high_q <= 1'b0;
      stuck_low_q  <= 1'b0;
    end else begin
      sync1_q      <= sync1_d;
      s_q          <= s_d;
      p_q          <= p_d;
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      hi_lat_q     <= hi_lat_d;
      high_q       <= high_d;
      period_q     <= period_d;
      valid_q      <= valid_d;
      stuck_high_q <= stuck_high_d;
      stuck_low_q  <= stuck_low_d;
    end
  end

  assign high_cycles   = high_q;
  assign period_cycles = period_q;
  assign meas_valid    = valid_q;
  assign stuck_high    = stuck_high_q;
  assign stuck_low     = stuck_low_q;

endmodule

// File: tb/tb_pwm_duty_meter.sv
// Directed self-checking bench for pwm_duty_meter.
module tb_pwm_duty_meter;

  logic       clk;
  logic       reset;
  logic       en;
  logic       pwm_in;
  logic [9:0] high_cycles;
  logic [9:0] period_cycles;
  logic       meas_valid;
  logic       stuck_high;
  logic       stuck_low;

  int checks;
  int failures;

  int cyc;
  int nvalid;
  int first_valid_cyc;
  int prev_valid_cyc;
  int last_valid_cyc;
  logic [9:0] last_hi;
  logic [9:0] last_per;
  logic prev_valid;
  int wide_err;
  int both_err;
  int phase;

  pwm_duty_meter #(
    .CNT_W  (10),
    .TIMEOUT(1000)
  ) u_dut (
    .clk          (clk),
    .reset        (reset),
    .en           (en),
    .pwm_in       (pwm_in),
    .high_cycles  (high_cycles),
    .period_cycles(period_cycles),
    .meas_valid   (meas_valid),
    .stuck_high   (stuck_high),
    .stuck_low    (stuck_low)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clock: sample #1 after the edge and record valid strobes.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (meas_valid) begin
      if (nvalid == 0) first_valid_cyc = cyc;
      nvalid++;
      prev_valid_cyc = last_valid_cyc;
      last_valid_cyc = cyc;
      last_hi = high_cycles;
      last_per = period_cycles;
      if (prev_valid) wide_err++;
    end
    if (stuck_high && stuck_low) both_err++;
    prev_valid = meas_valid;
  endtask

  // Drive n cycles of a PWM wave with the given high/period, phase continuous.
  task automatic run(input int hi, input int per, input int n);
    for (int i = 0; i < n; i++) begin
      pwm_in = (phase < hi);
      phase = (phase + 1) % per;
      tick();
    end
  endtask

  task automatic clear_stats();
    nvalid = 0;
    first_valid_cyc = -1;
    prev_valid_cyc = -1;
    last_valid_cyc = -1;
    last_hi = '0;
    last_per = '0;
  endtask

  task automatic apply_reset();
    pwm_in = 1'b0;
    en = 1'b1;
    phase = 0;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    clear_stats();
  endtask

  task automatic test_reset();
    pwm_in = 1'b0;
    en = 1'b1;
    reset = 1'b1;
    tick();
    tick();
    checks++;
    if (high_cycles !== 10'd0) begin
      failures++; $display("FAIL reset_high got=%0d exp=0", high_cycles);
    end
    checks++;
    if (period_cycles !== 10'd0) begin
      failures++; $display("FAIL reset_period got=%0d exp=0", period_cycles);
    end
    checks++;
    if (meas_valid !== 1'b0) begin
      failures++; $display("FAIL reset_valid got=%0b exp=0", meas_valid);
    end
    checks++;
    if (stuck_high !== 1'b0 || stuck_low !== 1'b0) begin
      failures++; $display("FAIL reset_stuck got=%0b%0b exp=00", stuck_high, stuck_low);
    end
    reset = 1'b0;
  endtask

  task automatic test_dc50();
    int c0;
    apply_reset();
    c0 = cyc;
    run(128, 256, 1024);
    checks++;
    if (nvalid !== 3) begin
      failures++; $display("FAIL dc50_count got=%0d exp=3", nvalid);
    end
    checks++;
    if (first_valid_cyc !== c0 + 259) begin
      failures++; $display("FAIL dc50_first got=%0d exp=%0d", first_valid_cyc - c0, 259);
    end
    checks++;
    if (last_valid_cyc - prev_valid_cyc !== 256) begin
      failures++; $display("FAIL dc50_spacing got=%0d exp=256", last_valid_cyc - prev_valid_cyc);
    end
    checks++;
    if (last_hi !== 10'd128 || last_per !== 10'd256) begin
      failures++; $display("FAIL dc50_vals got=%0d/%0d exp=128/256", last_hi, last_per);
    end
    checks++;
    if (stuck_high !== 1'b0 || stuck_low !== 1'b0) begin
      failures++; $display("FAIL dc50_stuck got=%0b%0b exp=00", stuck_high, stuck_low);
    end
  endtask

  task automatic test_en_gate();
    int c0;
    clear_stats();
    en = 1'b0;
    run(128, 256, 600);
    checks++;
    if (nvalid !== 0) begin
      failures++; $display("FAIL en_off_valid got=%0d exp=0", nvalid);
    end
    checks++;
    if (high_cycles !== 10'd128 || period_cycles !== 10'd256) begin
      failures++;
      $display("FAIL en_off_hold got=%0d/%0d exp=128/256", high_cycles, period_cycles);
    end
    checks++;
    if (stuck_high !== 1'b0 || stuck_low !== 1'b0) begin
      failures++; $display("FAIL en_off_stuck got=%0b%0b exp=00", stuck_high, stuck_low);
    end
    en = 1'b1;
    c0 = cyc;
    run(128, 256, 434);
    checks++;
    if (nvalid !== 1) begin
      failures++; $display("FAIL en_on_count got=%0d exp=1", nvalid);
    end
    checks++;
    if (first_valid_cyc !== c0 + 427) begin
      failures++; $display("FAIL en_on_first got=%0d exp=427", first_valid_cyc - c0);
    end
    checks++;
    if (last_hi !== 10'd128 || last_per !== 10'd256) begin
      failures++; $display("FAIL en_on_vals got=%0d/%0d exp=128/256", last_hi, last_per);
    end
  endtask

  task automatic test_dc_switch();
    clear_stats();
    run(64, 256, 768);
    checks++;
    if (last_hi !== 10'd64 || last_per !== 10'd256) begin
      failures++; $display("FAIL dc25_vals got=%0d/%0d exp=64/256", last_hi, last_per);
    end
    clear_stats();
    run(192, 256, 768);
    checks++;
    if (nvalid < 3) begin
      failures++; $display("FAIL dc75_count got=%0d exp>=3", nvalid);
    end
    checks++;
    if (last_hi !== 10'd192 || last_per !== 10'd256) begin
      failures++; $display("FAIL dc75_vals got=%0d/%0d exp=192/256", last_hi, last_per);
    end
  endtask

  task automatic test_stuck_low();
    apply_reset();
    run(0, 256, 1000);
    checks++;
    if (stuck_low !== 1'b0) begin
      failures++; $display("FAIL stuck_low_early got=%0b exp=0", stuck_low);
    end
    run(0, 256, 1);
    checks++;
    if (stuck_low !== 1'b1 || stuck_high !== 1'b0) begin
      failures++; $display("FAIL stuck_low_set got=%0b%0b exp=01", stuck_high, stuck_low);
    end
    checks++;
    if (nvalid !== 0) begin
      failures++; $display("FAIL stuck_low_valid got=%0d exp=0", nvalid);
    end
    phase = 0;
    run(128, 256, 2);
    checks++;
    if (stuck_low !== 1'b1) begin
      failures++; $display("FAIL stuck_low_hold got=%0b exp=1", stuck_low);
    end
    run(128, 256, 1);
    checks++;
    if (stuck_low !== 1'b0 || stuck_high !== 1'b0) begin
      failures++; $display("FAIL stuck_low_clear got=%0b%0b exp=00", stuck_high, stuck_low);
    end
    run(128, 256, 300);
    checks++;
    if (nvalid !== 1 || last_hi !== 10'd128 || last_per !== 10'd256) begin
      failures++;
      $display("FAIL stuck_low_resume got=%0d:%0d/%0d exp=1:128/256", nvalid, last_hi, last_per);
    end
  endtask

  task automatic test_stuck_high();
    apply_reset();
    run(256, 256, 1100);
    checks++;
    if (stuck_high !== 1'b1 || stuck_low !== 1'b0) begin
      failures++; $display("FAIL stuck_high_set got=%0b%0b exp=10", stuck_high, stuck_low);
    end
    checks++;
    if (nvalid !== 0) begin
      failures++; $display("FAIL stuck_high_valid got=%0d exp=0", nvalid);
    end
    run(0, 256, 2);
    checks++;
    if (stuck_high !== 1'b1) begin
      failures++; $display("FAIL stuck_high_hold got=%0b exp=1", stuck_high);
    end
    run(0, 256, 1);
    checks++;
    if (stuck_high !== 1'b0 || stuck_low !== 1'b0) begin
      failures++; $display("FAIL stuck_high_clear got=%0b%0b exp=00", stuck_high, stuck_low);
    end
    run(0, 256, 125);
    phase = 0;
    run(128, 256, 300);
    checks++;
    if (nvalid !== 1 || last_hi !== 10'd128 || last_per !== 10'd256) begin
      failures++;
      $display("FAIL stuck_high_resume got=%0d:%0d/%0d exp=1:128/256", nvalid, last_hi, last_per);
    end
  endtask

  task automatic test_reset_mid();
    int c0;
    apply_reset();
    run(128, 256, 512);
    run(128, 256, 198);
    checks++;
    if (high_cycles !== 10'd128 || period_cycles !== 10'd256) begin
      failures++;
      $display("FAIL rmid_pre got=%0d/%0d exp=128/256", high_cycles, period_cycles);
    end
    reset = 1'b1;
    tick();
    checks++;
    if (high_cycles !== 10'd0 || period_cycles !== 10'd0 || meas_valid !== 1'b0 ||
        stuck_high !== 1'b0 || stuck_low !== 1'b0) begin
      failures++;
      $display("FAIL rmid_zero got=%0d/%0d v=%0b s=%0b%0b exp=0/0 v=0 s=00",
               high_cycles, period_cycles, meas_valid, stuck_high, stuck_low);
    end
    reset = 1'b0;
    clear_stats();
    phase = 0;
    c0 = cyc;
    run(128, 256, 300);
    checks++;
    if (nvalid !== 1 || first_valid_cyc !== c0 + 259) begin
      failures++;
      $display("FAIL rmid_first got=%0d@%0d exp=1@259", nvalid, first_valid_cyc - c0);
    end
    checks++;
    if (last_hi !== 10'd128 || last_per !== 10'd256) begin
      failures++; $display("FAIL rmid_vals got=%0d/%0d exp=128/256", last_hi, last_per);
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    cyc = 0;
    phase = 0;
    wide_err = 0;
    both_err = 0;
    prev_valid = 1'b0;
    reset = 1'b1;
    en = 1'b0;
    pwm_in = 1'b0;
    clear_stats();

    test_reset();
    test_dc50();
    test_en_gate();
    test_dc_switch();
    test_stuck_low();
    test_stuck_high();
    test_reset_mid();

    checks++;
    if (wide_err !== 0) begin
      failures++; $display("FAIL valid_width got=%0d wide strobes exp=0", wide_err);
    end
    checks++;
    if (both_err !== 0) begin
      failures++; $display("FAIL stuck_both got=%0d cycles exp=0", both_err);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
